// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_pkg
//  Purpose  : Shared definitions for the seven-segment scan controller:
//             active-low segment table for hex digits 0-F, the all-off
//             segment pattern and the digit-slot state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package sseg_pkg;

    // Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // Each digit slot opens with a dark window before the anode is driven.
    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } slot_state_e;

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/hex_to_sseg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_sseg
//  Purpose  : Combinational hex nibble to active-low seven-segment decoder.
//  Ports    : i_hex  [3:0]  nibble to display
//             o_seg  [6:0]  segments {g..a}, active-low
//  Revision : 1.0  initial release
// ============================================================================
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule : hex_to_sseg
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for NUM_DIGITS common-anode
//             seven-segment digits. Each digit owns a slot of REFRESH_DIV
//             cycles whose first BLANK_CYCLES are dark (anti-ghosting).
//             Loaded data is held in a shadow register and promoted to the
//             display register only at a frame boundary (tear-free).
//  Ports    : clk, rst        clock, asynchronous active-high reset
//             data_in         hex nibbles, nibble i drives digit i (0 = right)
//             dp_in           decimal point request per digit, 1 = lit
//             digit_en        per-digit enable, sampled live
//             blank_lz        suppress leading zeros, sampled live
//             load            one-cycle capture strobe for data_in/dp_in
//             an              anodes, active-low
//             segs            segments {g..a}, active-low
//             dp              decimal point, active-low
//             frame_done      one-cycle pulse after the last slot of a frame
//             pending         loaded value not yet on the display
//  Revision : 1.0  initial release
// ============================================================================
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int CNT_W        = $clog2(REFRESH_DIV)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              segs,
    output logic                    dp,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] c_presc_last = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_blank_len  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Scan counter state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]        r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame_done;

    // ------------------------------------------------------------------
    // Double-buffered data
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    slot_state_e             r_state;
    slot_state_e             w_state_nxt;
    logic [NUM_DIGITS-1:0]   r_an_pat;
    logic [6:0]              r_segs_pat;
    logic                    r_dp_pat;
    logic [NUM_DIGITS-1:0]   w_an_pat_nxt;
    logic [6:0]              w_segs_pat_nxt;
    logic                    w_dp_pat_nxt;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_nib;
    logic                    w_dp_bit;
    logic                    w_en_bit;
    logic                    w_upper_zero;
    logic                    w_lz_blank;
    logic                    w_suppress;
    logic [6:0]              w_seg_dec;

    assign w_tick = (r_presc == c_presc_last);
    assign w_wrap = w_tick && (r_idx == c_idx_last);

    // ------------------------------------------------------------------
    // Prescaler, digit index and frame pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load handshake. A load landing on the wrap tick bypasses the shadow
    // so the new value is shown from the very next frame with no pending.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_disp      <= '0;
            r_disp_dp   <= '0;
            r_pending   <= 1'b0;
        end else if (w_wrap) begin
            if (load) begin
                r_disp    <= data_in;
                r_disp_dp <= dp_in;
            end else if (r_pending) begin
                r_disp    <= r_shadow;
                r_disp_dp <= r_shadow_dp;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_shadow    <= data_in;
            r_shadow_dp <= dp_in;
            r_pending   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Current-digit selection and leading-zero detection. The leading-zero
    // test requires every nibble at or above the current index to be zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_nib        = 4'h0;
        w_dp_bit     = 1'b0;
        w_en_bit     = 1'b0;
        w_upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_nib    = r_disp[4*k +: 4];
                w_dp_bit = r_disp_dp[k];
                w_en_bit = digit_en[k];
            end
            if ((IDX_W'(k) >= r_idx) && (r_disp[4*k +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_lz_blank = blank_lz && (r_idx != '0) && w_upper_zero;
    assign w_suppress = !w_en_bit || w_lz_blank;

    hex_to_sseg u_dec (
        .i_hex (w_nib),
        .o_seg (w_seg_dec)
    );

    // ------------------------------------------------------------------
    // Slot FSM: the state follows the prescaler position; the drive
    // pattern is precomputed and gated by the registered state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = S_BLANK;
        w_an_pat_nxt   = '1;
        w_segs_pat_nxt = SEG_OFF;
        w_dp_pat_nxt   = 1'b1;

        if (r_presc >= c_blank_len) begin
            w_state_nxt = S_DRIVE;
        end

        if (!w_suppress) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                w_an_pat_nxt[k] = (IDX_W'(k) != r_idx);
            end
            w_segs_pat_nxt = w_seg_dec;
            w_dp_pat_nxt   = ~w_dp_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_BLANK;
            r_an_pat   <= '1;
            r_segs_pat <= SEG_OFF;
            r_dp_pat   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_an_pat   <= w_an_pat_nxt;
            r_segs_pat <= w_segs_pat_nxt;
            r_dp_pat   <= w_dp_pat_nxt;
        end
    end

    assign an         = (r_state == S_DRIVE) ? r_an_pat   : '1;
    assign segs       = (r_state == S_DRIVE) ? r_segs_pat : SEG_OFF;
    assign dp         = (r_state == S_DRIVE) ? r_dp_pat   : 1'b1;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule : sseg_scan_ctrl
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_ctrl
//  Purpose  : Self-checking bench for sseg_scan_ctrl. A 4-digit instance is
//             compared every cycle against a frame/slot arithmetic model; an
//             8-digit instance is observed for scan coverage and frame period.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_ctrl;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int B  = 1;
    localparam int N8 = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4*N-1:0] data_in;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   digit_en;
    logic           blank_lz;
    logic           load;
    logic [N-1:0]   an;
    logic [6:0]     segs;
    logic           dp;
    logic           frame_done;
    logic           pending;

    logic [4*N8-1:0] data8;
    logic [N8-1:0]   dp8;
    logic [N8-1:0]   en8;
    logic            lz8;
    logic            ld8;
    logic [N8-1:0]   an8;
    logic [6:0]      segs8;
    logic            dp8_o;
    logic            fd8;
    logic            pend8;

    sseg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .blank_lz(blank_lz), .load(load),
        .an(an), .segs(segs), .dp(dp), .frame_done(frame_done), .pending(pending)
    );

    sseg_scan_ctrl #(.NUM_DIGITS(N8), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut8 (
        .clk(clk), .rst(rst), .data_in(data8), .dp_in(dp8),
        .digit_en(en8), .blank_lz(lz8), .load(ld8),
        .an(an8), .segs(segs8), .dp(dp8_o), .frame_done(fd8), .pending(pend8)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] ref_seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: cycles elapsed since reset release decide slot position and
    // digit; display content changes only at frame boundaries.
    int           m_edges;
    logic [15:0]  m_disp, m_shadow;
    logic [3:0]   m_disp_dp, m_shadow_dp;
    bit           m_pending;

    task automatic model_reset();
        m_edges     = 0;
        m_disp      = '0;
        m_shadow    = '0;
        m_disp_dp   = '0;
        m_shadow_dp = '0;
        m_pending   = 0;
    endtask

    // One clock with load=ld; checks every output after the edge.
    task automatic step(input bit ld);
        int         pos, dig;
        bit         lz, wrap;
        logic [3:0] nib;
        logic [N-1:0] e_an;
        logic [6:0] e_segs;
        logic       e_dp;
        load = ld;
        pos  = m_edges % R;
        dig  = (m_edges / R) % N;
        nib  = m_disp[dig*4 +: 4];
        lz   = blank_lz && (dig > 0) && ((m_disp >> (4*dig)) == 16'h0);
        if (pos < B || !digit_en[dig] || lz) begin
            e_an = '1; e_segs = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an = ~(N'(1) << dig); e_segs = ref_seg[nib]; e_dp = ~m_disp_dp[dig];
        end
        wrap = (pos == R-1) && (dig == N-1);
        if (wrap) begin
            if (ld) begin
                m_disp = data_in; m_disp_dp = dp_in;
            end else if (m_pending) begin
                m_disp = m_shadow; m_disp_dp = m_shadow_dp;
            end
            m_pending = 0;
        end else if (ld) begin
            m_shadow = data_in; m_shadow_dp = dp_in; m_pending = 1;
        end
        m_edges++;
        @(posedge clk); #1;
        checks++;
        if (an !== e_an) begin errors++; $display("FAIL an t=%0t got=%b exp=%b", $time, an, e_an); end
        checks++;
        if (segs !== e_segs) begin errors++; $display("FAIL segs t=%0t got=%h exp=%h", $time, segs, e_segs); end
        checks++;
        if (dp !== e_dp) begin errors++; $display("FAIL dp t=%0t got=%b exp=%b", $time, dp, e_dp); end
        checks++;
        if (frame_done !== wrap) begin errors++; $display("FAIL frame_done t=%0t got=%b exp=%b", $time, frame_done, wrap); end
        checks++;
        if (pending !== m_pending) begin errors++; $display("FAIL pending t=%0t got=%b exp=%b", $time, pending, m_pending); end
        load = 1'b0;
    endtask

    // Advance until the next edge samples slot position p of digit d.
    task automatic step_to(input int p, input int d);
        for (int i = 0; i < R*N && !((m_edges % R) == p && ((m_edges / R) % N) == d); i++)
            step(0);
        checks++;
        if (!((m_edges % R) == p && ((m_edges / R) % N) == d)) begin
            errors++; $display("FAIL step_to got=%0d exp_pos=%0d", m_edges, p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'hF || segs !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0 || pending !== 1'b0) begin
            errors++; $display("FAIL reset_init got=%h/%h/%b/%b/%b exp=f/7f/1/0/0", an, segs, dp, frame_done, pending);
        end
        rst = 1'b0;
        model_reset();
        repeat (6) step(0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || segs !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0 || pending !== 1'b0) begin
            errors++; $display("FAIL reset_async got=%h/%h/%b/%b/%b exp=f/7f/1/0/0", an, segs, dp, frame_done, pending);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(0);
        step(0);
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL first_drive got=%b exp=1110", an); end
    endtask

    task automatic test_decode_dp();
        logic [6:0] s [N];
        logic [N-1:0] d;
        int last_fd, fd_bad;
        step_to(0, 1);
        data_in = 16'h12AF; dp_in = 4'b0100;
        step(1);
        step_to(R-1, N-1);
        step(0);
        for (int i = 0; i < N; i++) s[i] = 7'h7F;
        d = '1;
        for (int c = 0; c < R*N; c++) begin
            step(0);
            for (int k = 0; k < N; k++) if (an[k] === 1'b0) begin s[k] = segs; d[k] = dp; end
        end
        checks++;
        if (s[0] !== 7'h0E || s[1] !== 7'h08 || s[2] !== 7'h24 || s[3] !== 7'h79) begin
            errors++; $display("FAIL decode got=%h %h %h %h exp=0e 08 24 79", s[0], s[1], s[2], s[3]);
        end
        checks++;
        if (d !== 4'b1011) begin errors++; $display("FAIL dp_digit2 got=%b exp=1011", d); end
        last_fd = -1; fd_bad = 0;
        for (int c = 0; c < 3*R*N; c++) begin
            step(0);
            if (frame_done === 1'b1) begin
                if (last_fd >= 0 && c - last_fd != R*N) fd_bad++;
                last_fd = c;
            end
        end
        checks++;
        if (fd_bad != 0 || last_fd < 0) begin errors++; $display("FAIL fd_period got_bad=%0d exp=0", fd_bad); end
    endtask

    task automatic test_blank_window();
        int blanks, drives, multi;
        blanks = 0; drives = 0; multi = 0;
        step_to(0, 0);
        for (int c = 0; c < R*N; c++) begin
            step(0);
            if (an === 4'hF) blanks++; else drives++;
            if ($countones(~an) > 1) multi++;
        end
        checks++;
        if (blanks != N*B || drives != N*(R-B) || multi != 0) begin
            errors++; $display("FAIL blank_window got=%0d/%0d/%0d exp=%0d/%0d/0", blanks, drives, multi, N*B, N*(R-B));
        end
    endtask

    task automatic test_lz();
        int upper_lit;
        logic [6:0] s1, s0;
        blank_lz = 1'b1; dp_in = '0;
        step_to(0, 2);
        data_in = 16'h0070;
        step(1);
        step_to(R-1, N-1);
        step(0);
        upper_lit = 0; s1 = 7'h7F; s0 = 7'h7F;
        for (int c = 0; c < R*N; c++) begin
            step(0);
            if (an[3] === 1'b0 || an[2] === 1'b0) upper_lit++;
            if (an === 4'b1101) s1 = segs;
            if (an === 4'b1110) s0 = segs;
        end
        checks++;
        if (upper_lit != 0 || s1 !== 7'h78 || s0 !== 7'h40) begin
            errors++; $display("FAIL lz_0070 got=%0d/%h/%h exp=0/78/40", upper_lit, s1, s0);
        end
        data_in = 16'h0000;
        step(1);
        step_to(R-1, N-1);
        step(0);
        upper_lit = 0; s0 = 7'h7F;
        for (int c = 0; c < R*N; c++) begin
            step(0);
            if (an[3:1] !== 3'b111) upper_lit++;
            if (an === 4'b1110) s0 = segs;
        end
        checks++;
        if (upper_lit != 0 || s0 !== 7'h40) begin
            errors++; $display("FAIL lz_zero got=%0d/%h exp=0/40", upper_lit, s0);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        step_to(1, 1);
        data_in = 16'h1111; step(1);
        data_in = 16'h2222; step(0); step(1);
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL b2b_pending got=%b exp=1", pending); end
        step_to(R-1, N-1);
        step(0);
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL b2b_clear got=%b exp=0", pending); end
        repeat (R*N) step(0);
        step_to(R-1, N-1);
        data_in = 16'h3456;
        step(1);
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL wrap_load_pending got=%b exp=0", pending); end
        repeat (R*N) step(0);
    endtask

    task automatic test_digit_en();
        int bad;
        bad = 0;
        digit_en = 4'b1010;
        for (int c = 0; c < 2*R*N; c++) begin
            step(0);
            if (an[0] === 1'b0 || an[2] === 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL digit_en got=%0d exp=0", bad); end
        digit_en = '1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 1) == 0) data_in[15:8] = 8'h00;
            step($urandom_range(0, 7) == 0);
        end
        digit_en = '1; blank_lz = 1'b0;
    endtask

    task automatic test_eight_digits();
        logic [N8-1:0] seen;
        int multi, last_fd, pulses, bad_period;
        seen = '0; multi = 0; last_fd = -1; pulses = 0; bad_period = 0;
        for (int c = 0; c < 110; c++) begin
            step(0);
            seen |= ~an8;
            if ($countones(~an8) > 1) multi++;
            if (fd8 === 1'b1) begin
                if (last_fd >= 0 && c - last_fd != R*N8) bad_period++;
                last_fd = c;
                pulses++;
            end
        end
        checks++;
        if (seen !== 8'hFF || multi != 0) begin errors++; $display("FAIL an8_scan got=%h/%0d exp=ff/0", seen, multi); end
        checks++;
        if (pulses < 2 || bad_period != 0) begin errors++; $display("FAIL fd8_period got=%0d/%0d exp>=2/0", pulses, bad_period); end
    endtask

    initial begin
        rst = 1'b1;
        data_in = '0; dp_in = '0; digit_en = '1; blank_lz = 1'b0; load = 1'b0;
        data8 = '0; dp8 = '0; en8 = '1; lz8 = 1'b0; ld8 = 1'b0;
        model_reset();
        test_reset();
        test_decode_dp();
        test_blank_window();
        test_lz();
        test_back_to_back();
        test_digit_en();
        test_random();
        test_eight_digits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sseg_scan_ctrl
`default_nettype wire

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Parametrised, time-multiplexed seven-segment scan controller: drives NUM_DIGITS common-anode digits from one packed hex word.
- Successor to the two-digit display FSM. Adds:
  - configurable digit count and refresh rate
  - anti-ghosting blank window
  - per-digit enable and decimal point
  - leading-zero blanking
  - tear-free double-buffered loading
- Sits between datapath result registers and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (range 2..8).
- REFRESH_DIV, 100000: clk cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off.
- CNT_W, $clog2(REFRESH_DIV): prescaler width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data_in  in  4*NUM_DIGITS  hex nibbles; nibble i ([4i+3:4i]) drives digit i, digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- digit_en  in  NUM_DIGITS  1 = digit may light
- blank_lz  in  1  1 = suppress leading zeros
- load  in  1  one-cycle strobe; capture data_in/dp_in
- an  out  NUM_DIGITS  anodes, active-low
- segs  out  7  segments {g..a}, active-low
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse when the last digit slot ends
- pending  out  1  1 = loaded value not yet displayed

Behaviour:
- Reset (async, immediate):
  - an all 1s, segs 7'h7F, dp 1, frame_done 0, pending 0.
  - Prescaler 0, digit index 0, shadow and display registers 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 every clk.
  - At terminal count (tick): index advances; after NUM_DIGITS-1 it wraps to 0.
- frame_done:
  - Asserted in the cycle after the tick that wraps the index to 0.
  - Width exactly one cycle.
- Load handshake:
  - load=1 copies data_in/dp_in into the shadow register and sets pending.
  - On the wrap tick, if pending=1: shadow moves to the display register and pending clears.
  - load coincident with the wrap tick: the new data_in goes straight to display; pending stays 0.
  - Back-to-back loads within a frame: the last one wins.
- Output FSM per slot (registered outputs, one-cycle latency from prescaler/index):
  - BLANK state, prescaler < BLANK_CYCLES: an all 1s, segs 7'h7F, dp 1.
  - DRIVE state, otherwise: an has bit[index]=0 and all other bits 1. segs = decode(display nibble[index]). dp = ~display_dp[index].
- Digit suppression (an stays all 1s for the whole slot; timing unchanged):
  - digit_en[index]=0.
  - Leading-zero blank: blank_lz=1, index>0, and every display nibble from NUM_DIGITS-1 down to index is 0.
  - Digit 0 is never leading-zero blanked.
  - A dp request on a blanked digit is also suppressed.
- Decode: 0-F to standard active-low patterns; for example 0 is 7'h40, 8 is 7'h00, F is 7'h0E.
- Async reset mid-slot: outputs blank immediately; the scan restarts at digit 0 with a fresh prescaler.
- digit_en / blank_lz are sampled live each cycle and are not double-buffered.

Decomposition:
- Shared package sseg_pkg:
  - 16-entry active-low segment constant table
  - SEG_OFF = 7'h7F
  - the digit-slot state enum (BLANK, DRIVE)
- One sub-module: reuse hex_to_sseg (4-bit in, 7-bit active-low out) as the decoder, instantiated once on the muxed nibble.
- The scan counter stays inline.

Test Plan:
(Unless noted, NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.)
1. Assert rst mid-slot, no clk edge -> an=4'hF, segs=7'h7F, dp=1 immediately. Release -> first DRIVE shows digit 0 with an=4'b1110.
2. load with data_in=16'h12AF, dp_in=4'b0100, before the wrap tick -> next frame shows digit 0 segs=7'h0E, digit 1 7'h08, digit 2 7'h24 with dp=0, digit 3 7'h79. frame_done pulses every 16 cycles.
3. Each slot -> exactly 1 blank cycle (an=4'hF) followed by 3 drive cycles. No cycle ever has two anodes low.
4. blank_lz=1, data_in=16'h0070 -> digits 3 and 2 are dark. Digit 1 shows 7'h78; digit 0 shows 7'h40. data_in=0 -> only digit 0 lit, showing 7'h40.
5. Two loads (16'h1111, then 16'h2222) mid-frame -> pending=1 until wrap, then display shows 2222. A load on the wrap cycle -> shown in the new frame, pending=0.
6. digit_en=4'b1010 -> an never drives bits 0 or 2 low. NUM_DIGITS=8 build -> an cycles through all 8 positions; frame_done period 32 cycles.
